ysyx_exu_csr_file: RTL and testbench
====================================

Name: ysyx_exu_csr_file

Overview:
Parametrised machine-mode CSR unit for the EXU stage. It replaces the fixed 4-register CSR store with the following:
- Full CSRRW/CSRRS/CSRRC semantics with a registered request/response handshake.
- Trap entry and mret sequencing that produce a redirect PC.
- mscratch, mtval and mie/mip shadow registers.
- 64-bit mcycle/minstret counters.
- Illegal-access detection.
It sits between EXU issue and the WBU; the IFU consumes the redirect outputs.

Parameters:
XLEN, 32, datapath width (32 only; 64 reserved, counters then single-word)
CNT_W, 64, mcycle/minstret width
VENDOR_ID, 32'h79737978, mvendorid read value
ARCH_ID, 32'h015fde77, marchid read value
MTVEC_RST, 0, mtvec reset value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CSR instruction request
req_ready  out  1  unit can accept a request
req_op  in  2  csr_op_t: 0 NONE, 1 RW, 2 RS, 3 RC
req_addr  in  12  CSR address
req_wdata  in  XLEN  rs1 value or zero-extended uimm
req_wen  in  1  0 when rs1=x0 / uimm=0 for RS/RC (suppresses write side effects)
rsp_valid  out  1  response valid, one cycle after accept
rsp_rdata  out  XLEN  old CSR value
rsp_illegal  out  1  illegal CSR access
trap_valid  in  1  take exception this cycle
trap_cause  in  XLEN  mcause value (bit XLEN-1 = interrupt)
trap_epc  in  XLEN  faulting PC
trap_tval  in  XLEN  mtval value
mret_valid  in  1  execute mret
retire  in  1  instruction retired (minstret++)
redirect_valid  out  1  PC redirect pulse
redirect_pc  out  XLEN  trap target or mepc
mie_o  out  1  mstatus.MIE for the interrupt gate

Behaviour:
- Reset: all CSRs 0 except mtvec=MTVEC_RST. Outputs: rsp_valid=0, redirect_valid=0, rsp_rdata=0, rsp_illegal=0, req_ready=1. A reset mid-request drops the pending response.
- Address map: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh/instret/instreth 0xC00/0xC80/0xC02/0xC82 (read-only), mvendorid 0xF11, marchid 0xF12, mhartid 0xF14 (reads 0).
- Accept when req_valid & req_ready. req_ready = ~rsp_valid | ~trap_valid, so the unit holds off while a trap is in flight.
- Response is registered: rsp_valid is asserted exactly 1 cycle after accept, for 1 cycle. rsp_rdata carries the pre-write value.
- Write value:
  - RW → wdata.
  - RS → old | wdata.
  - RC → old & ~wdata.
  - Writes apply on the accept edge when (op==RW) or req_wen.
- Illegal cases:
  - Unmapped address.
  - Write attempt (per the rule above) to a read-only address (addr[11:10]==2'b11).
  - op==NONE.
  - On illegal: no state change, rsp_rdata=0, rsp_illegal=1.
- WARL masks:
  - mstatus: only MIE(3), MPIE(7) writable; MPP(12:11) reads 2'b11.
  - mepc: bits[1:0] forced 0.
  - mtvec: mode field[1:0] is legal only for 0/1; values 2/3 store 0.
- Trap (trap_valid):
  - mepc←trap_epc&~3, mcause←trap_cause, mtval←trap_tval, MPIE←MIE, MIE←0.
  - redirect_valid=1 next cycle.
  - redirect_pc = base (mtvec&~3) when mode==0, or when mode==1 and cause is an exception.
  - redirect_pc = base + 4*cause[XLEN-2:0] when mode==1 and cause is an interrupt.
- mret: MIE←MPIE, MPIE←1; redirect_pc=mepc next cycle.
- Priority in the same cycle: trap > mret > CSR write. A CSR write accepted in a trap cycle is discarded; it is still reported with rsp_valid, with rsp_illegal=0.
- Counters:
  - mcycle increments every cycle. minstret increments when retire=1.
  - A CSR write to the low or high half in the same cycle overrides the increment for the whole counter; the untouched half holds.
  - Counters wrap at 2^CNT_W.
  - Reads of the high half return counter[63:32].
- Any write to mip is ignored (reads 0; reserved for a future CLINT hookup).
- redirect_valid is a single-cycle pulse.

Decomposition:
- Package ysyx_csr_pkg holds:
  - csr_op_t enum.
  - 12-bit address localparams.
  - mstatus bit indices (MIE_IDX=3, MPIE_IDX=7).
  - mtvec mode constants.
- The two counters are one sub-module, ysyx_csr_counter, instantiated twice. Parameters: CNT_W. Inputs: inc, wr_lo, wr_hi, wdata. Output: value.

Test Plan:
1. Reset, then CSRRW 0x305 with 0x80000101, then CSRRS 0x305 with 0 (wen=0) → second response rdata=0x80000101. The stored mtvec has mode 1, base 0x80000100.
2. CSRRS mstatus with 0x8, then trap_valid with cause=11, epc=0x80000046 → mepc=0x80000044, MIE=0, MPIE=1. Redirect pulses with 0x80000100 (mtvec base from test 1, exception cause ignores vectoring).
3. Set mtvec=0x80000001, trap with cause=0x80000007 → redirect_pc=0x8000001C. Then mret → redirect_pc=mepc, MIE=1, MPIE=1.
4. CSRRW 0xF11 with wen=1 → rsp_illegal=1, rdata=0. CSRRS 0xF11 with wen=0 → rdata=0x79737978, illegal=0. Access to unmapped 0x7C0 → illegal.
5. Write mcycle=0xFFFFFFFF and mcycleh=0, then run 2 cycles → mcycleh reads 1 and mcycle wraps. Writing mcycle while retire=1 → the written value wins.
6. Same-cycle trap_valid and CSRRW mscratch=0x1234 → mscratch unchanged and trap redirect issued. Asserting rst while rsp_valid is pending → rsp_valid=0 next cycle.

Source files
------------

// File: rtl/ysyx_csr_pkg.sv
// rtl/ysyx_csr_pkg.sv - shared types and constants for the EXU machine-mode CSR unit
//
// Purpose: CSR operation encoding, 12-bit CSR address map, mstatus bit
// positions and mtvec mode encodings shared by the CSR file and its bench.
// Ports: none (package).
package ysyx_csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MIE_IDX    = 3;
  localparam int MPIE_IDX   = 7;
  localparam int MPP_LO_IDX = 11;
  localparam int MPP_HI_IDX = 12;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  // The top two address bits equal to 2'b11 mark a read-only CSR.
  function automatic logic csr_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/ysyx_csr_counter.sv
// rtl/ysyx_csr_counter.sv - free-running wide counter with per-half CSR write override
//
// Purpose: one mcycle/minstret style counter. A write to either half takes
// precedence over the increment for the whole counter in that cycle; the
// half not written keeps its value. Wraps naturally at 2^CNT_W.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears the counter)
//   inc       - increment request for this cycle
//   wr_lo     - load wdata into the low half
//   wr_hi     - load wdata into the high half
//   wdata     - half-width write data
//   value     - current counter value
module ysyx_csr_counter #(
  parameter int CNT_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               wr_lo,
  input  logic               wr_hi,
  input  logic [CNT_W/2-1:0] wdata,
  output logic [CNT_W-1:0]   value
);

  localparam int HALF = CNT_W / 2;

  logic [HALF-1:0] lo_next;
  logic [HALF-1:0] hi_next;

  always_comb begin
    lo_next = wr_lo ? wdata : value[HALF-1:0];
    hi_next = wr_hi ? wdata : value[CNT_W-1:HALF];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wr_lo | wr_hi) begin
      value <= {hi_next, lo_next};
    end else if (inc) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_exu_csr_file.sv
// rtl/ysyx_exu_csr_file.sv - machine-mode CSR unit with trap/mret sequencing for the EXU
//
// Purpose: executes CSRRW/CSRRS/CSRRC with a one-cycle registered response,
// takes traps and mret and issues a one-cycle PC redirect, holds the
// machine CSRs and the mcycle/minstret counters, flags illegal accesses.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   req_valid/req_ready          - CSR request handshake
//   req_op/req_addr/req_wdata    - operation, CSR address, rs1/uimm operand
//   req_wen                      - operand is non-zero (enables RS/RC writes)
//   rsp_valid/rsp_rdata/rsp_illegal - response: pre-write value, illegal flag
//   trap_valid/trap_cause/trap_epc/trap_tval - exception/interrupt entry
//   mret_valid                   - return from trap
//   retire                       - instruction retired this cycle
//   redirect_valid/redirect_pc   - PC redirect pulse toward the IFU
//   mie_o                        - mstatus.MIE for the interrupt gate
module ysyx_exu_csr_file
  import ysyx_csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              CNT_W     = 64,
  parameter logic [XLEN-1:0] VENDOR_ID = 32'h79737978,
  parameter logic [XLEN-1:0] ARCH_ID   = 32'h015fde77,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_wen,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            retire,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mie_o
);

  csr_op_t op;

  logic            accept;
  logic            write_attempt;
  logic            mapped;
  logic            illegal;
  logic            csr_we;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] mtvec_wr;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  logic [CNT_W-1:0] mcycle;
  logic [CNT_W-1:0] minstret;

  assign op    = csr_op_t'(req_op);
  assign mie_o = mstatus_mie;

  // Stall only when a response is still on the bus and a trap is in flight.
  assign req_ready = ~rsp_valid | ~trap_valid;
  assign accept    = req_valid & req_ready;

  // RW always writes; RS/RC write only when the operand is not x0/zero.
  assign write_attempt = (op == CSR_OP_RW) | req_wen;

  always_comb begin
    mstatus_val                         = '0;
    mstatus_val[MPP_HI_IDX:MPP_LO_IDX]  = 2'b11;
    mstatus_val[MPIE_IDX]               = mstatus_mpie;
    mstatus_val[MIE_IDX]                = mstatus_mie;
  end

  always_comb begin
    mapped  = 1'b1;
    old_val = '0;
    case (req_addr)
      CSR_MSTATUS:                old_val = mstatus_val;
      CSR_MIE:                    old_val = mie_q;
      CSR_MTVEC:                  old_val = mtvec_q;
      CSR_MSCRATCH:               old_val = mscratch_q;
      CSR_MEPC:                   old_val = mepc_q;
      CSR_MCAUSE:                 old_val = mcause_q;
      CSR_MTVAL:                  old_val = mtval_q;
      CSR_MIP:                    old_val = '0;
      CSR_MCYCLE, CSR_CYCLE:      old_val = mcycle[XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH:    old_val = mcycle[CNT_W-1:CNT_W-XLEN];
      CSR_MINSTRET, CSR_INSTRET:  old_val = minstret[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[CNT_W-1:CNT_W-XLEN];
      CSR_MVENDORID:              old_val = VENDOR_ID;
      CSR_MARCHID:                old_val = ARCH_ID;
      CSR_MHARTID:                old_val = '0;
      default:                    mapped  = 1'b0;
    endcase
  end

  assign illegal = (op == CSR_OP_NONE) | ~mapped |
                   (write_attempt & csr_read_only(req_addr));

  // A trap in the same cycle discards the CSR write entirely.
  assign csr_we = accept & ~illegal & write_attempt & ~trap_valid;

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_OP_RW: new_val = req_wdata;
      CSR_OP_RS: new_val = old_val | req_wdata;
      CSR_OP_RC: new_val = old_val & ~req_wdata;
      default:   new_val = old_val;
    endcase
  end

  // Reserved mtvec modes 2/3 fall back to direct mode.
  always_comb begin
    mtvec_wr = new_val;
    if (new_val[1:0] > MTVEC_MODE_VECTORED) begin
      mtvec_wr[1:0] = MTVEC_MODE_DIRECT;
    end
  end

  // Only interrupts are vectored; exceptions always land on the base.
  always_comb begin
    trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
    trap_target = trap_base;
    if ((mtvec_q[1:0] == MTVEC_MODE_VECTORED) && trap_cause[XLEN-1]) begin
      trap_target = trap_base + {trap_cause[XLEN-3:0], 2'b00};
    end
  end

  ysyx_csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_we && (req_addr == CSR_MCYCLE)),
    .wr_hi (csr_we && (req_addr == CSR_MCYCLEH)),
    .wdata (new_val),
    .value (mcycle)
  );

  ysyx_csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .wr_lo (csr_we && (req_addr == CSR_MINSTRET)),
    .wr_hi (csr_we && (req_addr == CSR_MINSTRETH)),
    .wdata (new_val),
    .value (minstret)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mstatus_mie    <= 1'b0;
      mstatus_mpie   <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      rsp_valid      <= accept;
      rsp_rdata      <= (accept & ~illegal) ? old_val : '0;
      rsp_illegal    <= accept & illegal & ~trap_valid;
      redirect_valid <= trap_valid | mret_valid;

      if (csr_we) begin
        case (req_addr)
          CSR_MSTATUS: begin
            // mret owns mstatus in its cycle.
            if (!mret_valid) begin
              mstatus_mie  <= new_val[MIE_IDX];
              mstatus_mpie <= new_val[MPIE_IDX];
            end
          end
          CSR_MIE:      mie_q      <= new_val;
          CSR_MTVEC:    mtvec_q    <= mtvec_wr;
          CSR_MSCRATCH: mscratch_q <= new_val;
          CSR_MEPC:     mepc_q     <= {new_val[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause_q   <= new_val;
          CSR_MTVAL:    mtval_q    <= new_val;
          default:      ;
        endcase
      end

      if (trap_valid) begin
        mepc_q       <= {trap_epc[XLEN-1:2], 2'b00};
        mcause_q     <= trap_cause;
        mtval_q      <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        redirect_pc  <= trap_target;
      end else if (mret_valid) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
        redirect_pc  <= mepc_q;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_exu_csr_file.sv
// tb/tb_ysyx_exu_csr_file.sv - self-checking bench for ysyx_exu_csr_file
module tb_ysyx_exu_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_wen;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        retire;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mie_o;

  always #5 clk = ~clk;

  ysyx_exu_csr_file dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wen(req_wen),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .mret_valid(mret_valid), .retire(retire),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mie_o(mie_o)
  );

  typedef struct {
    bit        rst;
    bit        req;
    bit [1:0]  op;
    bit [11:0] addr;
    bit [31:0] wdata;
    bit        wen;
    bit        trap;
    bit [31:0] cause;
    bit [31:0] epc;
    bit [31:0] tval;
    bit        mret;
    bit        retire;
    bit        e_rsp;
    bit        e_chk;
    bit [31:0] e_rdata;
    bit        e_ill;
    bit        e_redir;
    bit [31:0] e_pc;
    bit        e_mie;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural CSR state.
  bit [31:0] m_csr [int];
  bit        m_mie, m_mpie;
  bit [63:0] m_cycle, m_instret;
  bit        m_rsp_valid, m_illegal, m_redir;
  bit [31:0] m_rdata, m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_csr.delete();
    m_csr[12'h304] = 0; m_csr[12'h305] = 0; m_csr[12'h340] = 0;
    m_csr[12'h341] = 0; m_csr[12'h342] = 0; m_csr[12'h343] = 0;
    m_mie = 0; m_mpie = 0; m_cycle = 0; m_instret = 0;
    m_rsp_valid = 0; m_illegal = 0; m_redir = 0; m_rdata = 0; m_pc = 0;
  endtask

  function automatic bit [31:0] m_read(input bit [11:0] a, output bit ok);
    ok = 1'b1;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: return m_csr[int'(a)];
      12'h344, 12'hF14: return 32'h0;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'hF11: return 32'h79737978;
      12'hF12: return 32'h015fde77;
      default: begin ok = 1'b0; return 32'h0; end
    endcase
  endfunction

  task automatic model_step(input vec_t v);
    bit acc, ok, ill, wr;
    bit [31:0] old, nv, base, pre_mepc, pre_mtvec;
    bit pre_mie, pre_mpie;
    bit [63:0] cyc_n, ins_n;
    if (v.rst) begin model_reset(); return; end
    pre_mie = m_mie; pre_mpie = m_mpie;
    pre_mepc = m_csr[12'h341]; pre_mtvec = m_csr[12'h305];
    acc = v.req && (!m_rsp_valid || !v.trap);
    old = m_read(v.addr, ok);
    wr  = (v.op == 2'd1) || v.wen;
    ill = (v.op == 2'd0) || !ok || (wr && v.addr[11:10] == 2'b11);
    case (v.op)
      2'd1: nv = v.wdata;
      2'd2: nv = old | v.wdata;
      default: nv = old & ~v.wdata;
    endcase
    cyc_n = m_cycle + 1;
    ins_n = m_instret + (v.retire ? 64'd1 : 64'd0);
    m_rsp_valid = acc;
    m_rdata     = (acc && !ill) ? old : 32'h0;
    m_illegal   = acc && ill && !v.trap;
    if (acc && !ill && wr && !v.trap) begin
      case (v.addr)
        12'h300: if (!v.mret) begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_csr[12'h305] = (nv[1:0] > 2'd1) ? {nv[31:2], 2'b00} : nv;
        12'h341: m_csr[12'h341] = nv & ~32'h3;
        12'h304, 12'h340, 12'h342, 12'h343: m_csr[int'(v.addr)] = nv;
        12'hB00: cyc_n = {m_cycle[63:32], nv};
        12'hB80: cyc_n = {nv, m_cycle[31:0]};
        12'hB02: ins_n = {m_instret[63:32], nv};
        12'hB82: ins_n = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle = cyc_n; m_instret = ins_n;
    m_redir = v.trap || v.mret;
    if (v.trap) begin
      m_csr[12'h341] = v.epc & ~32'h3;
      m_csr[12'h342] = v.cause;
      m_csr[12'h343] = v.tval;
      m_mpie = pre_mie; m_mie = 0;
      base = pre_mtvec & ~32'h3;
      m_pc = (pre_mtvec[1:0] == 2'd1 && v.cause[31]) ? base + 4 * {1'b0, v.cause[30:0]} : base;
    end else if (v.mret) begin
      m_mie = pre_mpie; m_mpie = 1; m_pc = pre_mepc;
    end
  endtask

  task automatic do_cycle(input vec_t v, input string tag);
    rst = v.rst; req_valid = v.req; req_op = v.op; req_addr = v.addr;
    req_wdata = v.wdata; req_wen = v.wen; trap_valid = v.trap;
    trap_cause = v.cause; trap_epc = v.epc; trap_tval = v.tval;
    mret_valid = v.mret; retire = v.retire;
    #1;
    if (!v.rst) check({tag, " req_ready"}, 32'(req_ready), 32'(!m_rsp_valid || !v.trap));
    model_step(v);
    @(posedge clk);
    #1;
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid) begin
      check({tag, " rsp_rdata"}, rsp_rdata, m_rdata);
      check({tag, " rsp_illegal"}, 32'(rsp_illegal), 32'(m_illegal));
    end
    check({tag, " redirect_valid"}, 32'(redirect_valid), 32'(m_redir));
    if (m_redir) check({tag, " redirect_pc"}, redirect_pc, m_pc);
    check({tag, " mie_o"}, 32'(mie_o), 32'(m_mie));
  endtask

  function automatic vec_t blank(input bit mie);
    vec_t v;
    v = '{default: 0};
    v.e_mie = mie;
    return v;
  endfunction

  function automatic vec_t rq(input bit [1:0] op, input bit [11:0] addr, input bit [31:0] wd,
                              input bit wen, input bit chk, input bit [31:0] rd,
                              input bit ill, input bit mie);
    vec_t v;
    v = blank(mie);
    v.req = 1; v.op = op; v.addr = addr; v.wdata = wd; v.wen = wen;
    v.e_rsp = 1; v.e_chk = chk; v.e_rdata = rd; v.e_ill = ill;
    return v;
  endfunction

  function automatic vec_t tr(input bit [31:0] cause, input bit [31:0] epc,
                              input bit [31:0] pc, input bit mie);
    vec_t v;
    v = blank(mie);
    v.trap = 1; v.cause = cause; v.epc = epc; v.tval = epc ^ 32'h5a5a;
    v.e_redir = 1; v.e_pc = pc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t v;
    bit [11:0] addrs [21] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'hF11, 12'hF12, 12'hF14, 12'h7C0, 12'h301};

    // Test plan 1-3: mtvec, trap entry, vectored interrupt, mret.
    tbl.push_back(rq(1, 12'h305, 32'h80000101, 1, 1, 32'h0, 0, 0));
    tbl.push_back(rq(2, 12'h305, 32'h0, 0, 1, 32'h80000101, 0, 0));
    tbl.push_back(rq(2, 12'h300, 32'h8, 1, 1, 32'h1800, 0, 1));
    tbl.push_back(tr(32'd11, 32'h80000046, 32'h80000100, 0));
    tbl.push_back(rq(2, 12'h341, 32'h0, 0, 1, 32'h80000044, 0, 0));
    tbl.push_back(rq(2, 12'h300, 32'h0, 0, 1, 32'h1880, 0, 0));
    tbl.push_back(rq(2, 12'h342, 32'h0, 0, 1, 32'hB, 0, 0));
    tbl.push_back(rq(1, 12'h305, 32'h80000001, 1, 1, 32'h80000101, 0, 0));
    tbl.push_back(rq(2, 12'h300, 32'h8, 1, 1, 32'h1880, 0, 1));
    tbl.push_back(tr(32'h80000007, 32'h80000010, 32'h8000001C, 0));
    v = blank(1); v.mret = 1; v.e_redir = 1; v.e_pc = 32'h80000010; tbl.push_back(v);
    tbl.push_back(rq(2, 12'h300, 32'h0, 0, 1, 32'h1888, 0, 1));
    // Test plan 4: read-only, unmapped, op NONE, WARL fields.
    tbl.push_back(rq(1, 12'hF11, 32'h1234, 1, 1, 32'h0, 1, 1));
    tbl.push_back(rq(2, 12'hF11, 32'h0, 0, 1, 32'h79737978, 0, 1));
    tbl.push_back(rq(2, 12'h7C0, 32'h0, 0, 1, 32'h0, 1, 1));
    tbl.push_back(rq(2, 12'hF12, 32'h0, 0, 1, 32'h015fde77, 0, 1));
    tbl.push_back(rq(0, 12'h340, 32'h0, 0, 1, 32'h0, 1, 1));
    tbl.push_back(rq(1, 12'h305, 32'h80000203, 1, 1, 32'h80000001, 0, 1));
    tbl.push_back(rq(2, 12'h305, 32'h0, 0, 1, 32'h80000200, 0, 1));
    tbl.push_back(rq(1, 12'h344, 32'hFFFF, 1, 1, 32'h0, 0, 1));
    tbl.push_back(rq(2, 12'h344, 32'h0, 0, 1, 32'h0, 0, 1));
    tbl.push_back(rq(1, 12'h341, 32'h12345677, 1, 1, 32'h80000010, 0, 1));
    tbl.push_back(rq(2, 12'h341, 32'h0, 0, 1, 32'h12345674, 0, 1));
    // Test plan 5: counter carry across halves, write beats retire.
    tbl.push_back(rq(1, 12'hB00, 32'hFFFFFFFF, 1, 0, 32'h0, 0, 1));
    tbl.push_back(rq(1, 12'hB80, 32'h0, 1, 0, 32'h0, 0, 1));
    tbl.push_back(blank(1));
    tbl.push_back(blank(1));
    tbl.push_back(rq(2, 12'hB80, 32'h0, 0, 1, 32'h1, 0, 1));
    tbl.push_back(rq(2, 12'hB00, 32'h0, 0, 1, 32'h2, 0, 1));
    v = rq(1, 12'hB02, 32'h55, 1, 0, 32'h0, 0, 1); v.retire = 1; tbl.push_back(v);
    tbl.push_back(rq(2, 12'hB02, 32'h0, 0, 1, 32'h55, 0, 1));
    tbl.push_back(rq(2, 12'hC82, 32'h0, 0, 1, 32'h0, 0, 1));
    tbl.push_back(rq(1, 12'hC00, 32'h7, 1, 1, 32'h0, 1, 1));
    // Test plan 6: trap vs CSR write, back-pressure, reset drops response.
    tbl.push_back(rq(1, 12'h340, 32'hAAAA, 1, 1, 32'h0, 0, 1));
    tbl.push_back(blank(1));
    v = rq(1, 12'h340, 32'h1234, 1, 1, 32'hAAAA, 0, 0);
    v.trap = 1; v.cause = 32'd2; v.epc = 32'h200; v.e_redir = 1; v.e_pc = 32'h80000200;
    tbl.push_back(v);
    tbl.push_back(rq(2, 12'h340, 32'h0, 0, 1, 32'hAAAA, 0, 0));
    v = rq(1, 12'h340, 32'h5555, 1, 0, 32'h0, 0, 0);
    v.e_rsp = 0; v.trap = 1; v.cause = 32'd3; v.epc = 32'h300; v.e_redir = 1; v.e_pc = 32'h80000200;
    tbl.push_back(v);
    tbl.push_back(rq(2, 12'h340, 32'h0, 0, 1, 32'hAAAA, 0, 0));
    v = rq(2, 12'h340, 32'h0, 0, 0, 32'h0, 0, 0); v.rst = 1; v.e_rsp = 0; tbl.push_back(v);
    tbl.push_back(rq(2, 12'h305, 32'h0, 0, 1, 32'h0, 0, 0));

    // Reset and check reset state.
    v = blank(0); v.rst = 1;
    rst = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_wen = 0;
    trap_valid = 0; trap_cause = 0; trap_epc = 0; trap_tval = 0; mret_valid = 0; retire = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_illegal", 32'(rsp_illegal), 32'h0);
    check("reset redirect_valid", 32'(redirect_valid), 32'h0);
    check("reset req_ready", 32'(req_ready), 32'h1);
    check("reset mie_o", 32'(mie_o), 32'h0);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      do_cycle(tbl[i], tag);
      check({tag, " exp rsp_valid"}, 32'(rsp_valid), 32'(tbl[i].e_rsp));
      if (tbl[i].e_rsp) begin
        if (tbl[i].e_chk) check({tag, " exp rsp_rdata"}, rsp_rdata, tbl[i].e_rdata);
        check({tag, " exp rsp_illegal"}, 32'(rsp_illegal), 32'(tbl[i].e_ill));
      end
      check({tag, " exp redirect_valid"}, 32'(redirect_valid), 32'(tbl[i].e_redir));
      if (tbl[i].e_redir) check({tag, " exp redirect_pc"}, redirect_pc, tbl[i].e_pc);
      check({tag, " exp mie_o"}, 32'(mie_o), 32'(tbl[i].e_mie));
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      v = blank(0);
      v.req    = ($urandom_range(0, 3) != 0);
      v.op     = 2'($urandom_range(0, 3));
      v.addr   = addrs[$urandom_range(0, 20)];
      v.wdata  = $urandom();
      v.wen    = 1'($urandom_range(0, 1));
      v.trap   = ($urandom_range(0, 11) == 0);
      v.cause  = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 15))};
      v.epc    = $urandom();
      v.tval   = $urandom();
      v.mret   = ($urandom_range(0, 11) == 0);
      v.retire = 1'($urandom_range(0, 1));
      do_cycle(v, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
